// File: rtl/iram_loader_if.sv
// Byte load-stream handshake between a source (master) and the IRAM loader (slave).
interface iram_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/iram_loader.sv
// Loads a little-endian byte stream (header, words, optional checksum) into microcode RAM.
// Define IRAM_LOADER_CKSUM_EN to add the trailing 32-bit checksum phase.
module iram_loader #(
    parameter int unsigned IRAM_SIZE = 21504
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    iram_loader_if.slave        in_if,
    output logic [14:0]         ram_addr,
    output logic [31:0]         ram_data,
    output logic                ram_wren,
    output logic                ram_rden,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IRAM_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    localparam logic [16:0] SIZE17 = 17'(IRAM_SIZE);

    state_t      state_q;
    state_t      state_d;
    state_t      end_state;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
    logic [14:0] base_q;
    logic [15:0] count_q;
    logic [15:0] index_q;
    logic [14:0] ram_addr_q;
    logic [31:0] ram_data_q;
    logic        error_q;
`ifdef IRAM_LOADER_CKSUM_EN
    logic [31:0] acc_q;
`endif

    logic        in_ready_c;
    logic        accept;
    logic        last_byte;
    logic [31:0] word;
    logic [16:0] span;
    logic        range_err;
    logic [15:0] index_inc;

    assign in_ready_c = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IRAM_LOADER_CKSUM_EN
                        || (state_q == S_CKSUM)
`endif
                        ;
    assign accept    = in_if.in_valid && in_ready_c;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    // Current byte completes the word; earlier bytes sit in shift_q, oldest in the low byte.
    assign word      = {in_if.in_data, shift_q};
    assign span      = {2'b00, word[14:0]} + {1'b0, word[31:16]};
    assign range_err = span > SIZE17;
    assign index_inc = index_q + 16'd1;

`ifdef IRAM_LOADER_CKSUM_EN
    assign end_state = S_CKSUM;
`else
    assign end_state = S_DONE;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_HDR;
            S_HDR: begin
                if (last_byte) begin
                    if (range_err)
                        state_d = S_ERR;
                    else if (word[31:16] == 16'd0)
                        state_d = end_state;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA:  if (last_byte) state_d = S_WRITE;
            S_WRITE: state_d = (index_inc == count_q) ? end_state : S_DATA;
`ifdef IRAM_LOADER_CKSUM_EN
            S_CKSUM: if (last_byte) state_d = (word == acc_q) ? S_DONE : S_ERR;
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            base_q     <= '0;
            count_q    <= '0;
            index_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            error_q    <= 1'b0;
`ifdef IRAM_LOADER_CKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                byte_cnt_q <= '0;
                shift_q    <= '0;
                base_q     <= '0;
                count_q    <= '0;
                index_q    <= '0;
                error_q    <= 1'b0;
`ifdef IRAM_LOADER_CKSUM_EN
                acc_q      <= '0;
`endif
            end
            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= {in_if.in_data, shift_q[23:8]};
            end
            if (state_q == S_HDR && last_byte) begin
                base_q  <= word[14:0];
                count_q <= word[31:16];
            end
            // Address/data are captured one cycle ahead so the write strobe is a clean state decode.
            if (state_q == S_DATA && last_byte) begin
                ram_addr_q <= base_q + index_q[14:0];
                ram_data_q <= word;
            end
            if (state_q == S_WRITE) begin
                index_q <= index_inc;
`ifdef IRAM_LOADER_CKSUM_EN
                acc_q   <= acc_q + ram_data_q;
`endif
            end
            if (state_d == S_ERR)
                error_q <= 1'b1;
        end
    end

    assign in_if.in_ready = in_ready_c;
    assign ram_addr       = ram_addr_q;
    assign ram_data       = ram_data_q;
    assign ram_wren       = (state_q == S_WRITE);
    assign ram_rden       = 1'b0;
    assign busy           = in_ready_c || (state_q == S_WRITE);
    assign done           = (state_q == S_DONE);
    assign error          = error_q;

endmodule

// File: tb/tb_iram_loader.sv
// Randomized self-checking bench for iram_loader against a stream-level reference model.
module tb_iram_loader;

    localparam int unsigned IRAM_SIZE = 21504;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [14:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        ram_rden;
    logic        busy;
    logic        done;
    logic        error;

    iram_loader_if sif ();

    iram_loader #(.IRAM_SIZE(IRAM_SIZE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_if    (sif),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_rden (ram_rden),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0]  tx_q[$];
    logic [46:0] wr_q[$];
    logic [46:0] exp_q[$];
    logic        exp_err;
    int unsigned done_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_wren) wr_q.push_back({ram_addr, ram_data});
            if (done) done_cnt++;
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int unsigned i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    endtask

    // Header plus cnt random words, optionally followed by a (possibly corrupted) checksum.
    task automatic build_stream(input logic [15:0] base, input logic [15:0] cnt, input bit ck_bad);
        logic [31:0] sum;
        logic [31:0] w;
        sum = '0;
        tx_q.delete();
        push_word({cnt, base});
        for (int unsigned i = 0; i < 32'(cnt); i++) begin
            w = $urandom;
            sum += w;
            push_word(w);
        end
`ifdef IRAM_LOADER_CKSUM_EN
        push_word(ck_bad ? sum ^ 32'h0000_0100 : sum);
`else
        if (ck_bad) sum = '0;
`endif
    endtask

    // Reference: interpret the byte stream directly as header / words / checksum.
    task automatic compute_expected();
        int unsigned base;
        int unsigned cnt;
        logic [31:0] w;
        logic [31:0] sum;
        exp_q.delete();
        sum = '0;
        base = (32'(tx_q[1]) * 256 + 32'(tx_q[0])) % 32768;
        cnt  = 32'(tx_q[3]) * 256 + 32'(tx_q[2]);
        exp_err = (base + cnt > IRAM_SIZE);
        if (!exp_err) begin
            for (int unsigned i = 0; i < cnt; i++) begin
                w = {tx_q[4+4*i+3], tx_q[4+4*i+2], tx_q[4+4*i+1], tx_q[4+4*i]};
                sum += w;
                exp_q.push_back({15'(base + i), w});
            end
`ifdef IRAM_LOADER_CKSUM_EN
            w = {tx_q[4+4*cnt+3], tx_q[4+4*cnt+2], tx_q[4+4*cnt+1], tx_q[4+4*cnt]};
            exp_err = (w != sum);
`endif
        end
    endtask

    task automatic run_session(input int unsigned n_send, input bit rand_valid, input int n_start);
        int unsigned idx;
        int unsigned cyc;
        bit          acc;
        idx = 0;
        cyc = 0;
        wr_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("error_cleared", 64'(error), 64'd0);
        while (idx < n_send && cyc < 4000) begin
            sif.in_data  = tx_q[idx];
            sif.in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            start        = (n_start >= 0 && idx == 32'(n_start)) ? 1'b1 : 1'b0;
            acc          = sif.in_valid && sif.in_ready;
            if (!busy) break;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        if (cyc >= 4000) check("drive_timeout", 64'(cyc), 64'd0);
        sif.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic finish_session(input string name);
        int unsigned cyc;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_end_timeout"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        compute_expected();
        check({name, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({name, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
        check({name, "_done"}, 64'(done_cnt), exp_err ? 64'd0 : 64'd1);
        check({name, "_error"}, 64'(error), 64'(exp_err));
    endtask

    task automatic ref_stream();
        tx_q.delete();
        push_word(32'h0002_0100);
        push_word(32'h1234_5678);
        push_word(32'hDEAD_BEEF);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        #3;
        check("rst_in_ready", 64'(sif.in_ready), 64'd0);
        check("rst_wren", 64'(ram_wren), 64'd0);
        check("rst_rden", 64'(ram_rden), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_data", 64'(ram_data), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        ref_stream();
`ifdef IRAM_LOADER_CKSUM_EN
        push_word(32'hF0E2_1567);
`endif
        run_session(tx_q.size(), 1'b0, -1);
        finish_session("ref");
        check("ref_first", wr_q.size() > 0 ? 64'(wr_q[0]) : '1, 64'({15'h0100, 32'h1234_5678}));
        check("ref_second", wr_q.size() > 1 ? 64'(wr_q[1]) : '1, 64'({15'h0101, 32'hDEAD_BEEF}));

        ref_stream();
`ifdef IRAM_LOADER_CKSUM_EN
        push_word(32'h0000_0000);
`endif
        run_session(tx_q.size(), 1'b1, -1);
        finish_session("ref_rand_valid");

        build_stream(16'h53FF, 16'd2, 1'b0);
        run_session(tx_q.size(), 1'b1, -1);
        finish_session("range_err");
        repeat (4) @(negedge clk);
        check("error_sticky", 64'(error), 64'd1);

        build_stream(16'h53FF, 16'd1, 1'b0);
        run_session(tx_q.size(), 1'b1, -1);
        finish_session("top_word");

        build_stream(16'd21500, 16'd4, 1'b0);
        run_session(tx_q.size(), 1'b0, -1);
        finish_session("exact_fit");

        build_stream(16'd21500, 16'd5, 1'b0);
        run_session(tx_q.size(), 1'b0, -1);
        finish_session("one_over");

        build_stream(16'h0040, 16'd0, 1'b0);
        run_session(tx_q.size(), 1'b1, -1);
        finish_session("count_zero");

        build_stream(16'h8100, 16'd2, 1'b0);
        run_session(tx_q.size(), 1'b1, -1);
        finish_session("base_bit15");

        build_stream(16'h0200, 16'd3, 1'b0);
        run_session(tx_q.size(), 1'b1, 6);
        finish_session("start_mid_data");

`ifdef IRAM_LOADER_CKSUM_EN
        build_stream(16'h0300, 16'd3, 1'b1);
        run_session(tx_q.size(), 1'b1, -1);
        finish_session("bad_cksum");
`endif

        for (int unsigned s = 0; s < 8; s++) begin
            build_stream(16'($urandom_range(0, IRAM_SIZE)), 16'($urandom_range(0, 5)), 1'b0);
            run_session(tx_q.size(), 1'b1, -1);
            finish_session("random");
        end

        build_stream(16'h0020, 16'd1, 1'b0);
        run_session(6, 1'b0, -1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(sif.in_ready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wren", 64'(ram_wren), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        check("mid_rst_addr", 64'(ram_addr), 64'd0);
        check("mid_rst_data", 64'(ram_data), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_nwr", 64'(wr_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
